// File: rtl/softmax_matrix_reader.sv
`default_nettype none
// ============================================================================
// softmax_matrix_reader: snapshots the softmax bus and streams it row-major
// as LANES-wide beats; optional row-sum check under SOFTMAX_ROW_SUM_CHECK_EN.
// Revision: 1.0
// ============================================================================
module softmax_matrix_reader #(
  parameter int DATA_WIDTH     = 8,
  parameter int MATRIX_NUM     = 12,
  parameter int OUTPUT_SHAPE_1 = 128,
  parameter int OUTPUT_SHAPE_2 = 128,
  parameter int LANES          = 16,
  parameter int SUM_TOL        = 4,
  localparam int TOTAL_BITS = DATA_WIDTH * MATRIX_NUM * OUTPUT_SHAPE_1 * OUTPUT_SHAPE_2,
  localparam int MAT_W      = (MATRIX_NUM > 1) ? $clog2(MATRIX_NUM) : 1,
  localparam int ROW_W      = (OUTPUT_SHAPE_1 > 1) ? $clog2(OUTPUT_SHAPE_1) : 1,
  localparam int COL_W      = (OUTPUT_SHAPE_2 > 1) ? $clog2(OUTPUT_SHAPE_2) : 1,
  localparam int BEAT_W     = DATA_WIDTH * LANES
) (
  input  logic                  clk_p,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [TOTAL_BITS-1:0] softmax_matrix,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BEAT_W-1:0]     out_data,
  output logic [MAT_W-1:0]      out_mat,
  output logic [ROW_W-1:0]      out_row,
  output logic [COL_W-1:0]      out_col,
  output logic                  out_row_last,
  output logic                  out_last,
  output logic                  row_sum_err
);

  localparam int IDX_W = $clog2(TOTAL_BITS) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  generate
    if (((OUTPUT_SHAPE_2 % LANES) != 0) || (SUM_TOL < 0)) begin : g_param_check
      $error("softmax_matrix_reader: OUTPUT_SHAPE_2 must be a multiple of LANES and SUM_TOL >= 0");
    end
  endgenerate

  logic [1:0]            state_q, state_d;
  logic [TOTAL_BITS-1:0] snap_q, snap_d;
  logic [MAT_W-1:0]      mat_q, mat_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [COL_W-1:0]      col_q, col_d;

  logic              streaming;
  logic              accept;
  logic              col_at_end;
  logic              row_at_end;
  logic              mat_at_end;
  logic [IDX_W-1:0]  elem_idx;
  logic [IDX_W-1:0]  bit_base;
  logic [BEAT_W-1:0] data_slice;

  assign streaming  = (state_q == S_STREAM);
  assign accept     = streaming && out_ready;
  assign col_at_end = (col_q == COL_W'(OUTPUT_SHAPE_2 - LANES));
  assign row_at_end = (row_q == ROW_W'(OUTPUT_SHAPE_1 - 1));
  assign mat_at_end = (mat_q == MAT_W'(MATRIX_NUM - 1));

  // Element offset of lane 0 inside the row-major snapshot.
  assign elem_idx   = (IDX_W'(mat_q) * IDX_W'(OUTPUT_SHAPE_1) + IDX_W'(row_q))
                      * IDX_W'(OUTPUT_SHAPE_2) + IDX_W'(col_q);
  assign bit_base   = elem_idx * IDX_W'(DATA_WIDTH);
  assign data_slice = snap_q[bit_base +: BEAT_W];

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    mat_d   = mat_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = softmax_matrix;
          mat_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (out_ready) begin
          if (col_at_end && row_at_end && mat_at_end) begin
            state_d = S_DONE;
          end
          if (col_at_end) begin
            col_d = '0;
            if (row_at_end) begin
              row_d = '0;
              mat_d = mat_at_end ? '0 : mat_q + MAT_W'(1);
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(LANES);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      mat_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      mat_q   <= mat_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign busy         = streaming;
  assign out_valid    = streaming;
  assign done         = (state_q == S_DONE);
  assign out_data     = streaming ? data_slice : '0;
  assign out_mat      = mat_q;
  assign out_row      = row_q;
  assign out_col      = col_q;
  assign out_row_last = streaming && col_at_end;
  assign out_last     = streaming && col_at_end && row_at_end && mat_at_end;

`ifdef SOFTMAX_ROW_SUM_CHECK_EN
  localparam int ACC_W = DATA_WIDTH + $clog2(OUTPUT_SHAPE_2) + 1;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] beat_sum;
  logic signed [ACC_W-1:0] row_total;
  logic signed [ACC_W:0]   deviation;
  logic        [ACC_W:0]   deviation_abs;
  logic                    err_q, err_d;

  always_comb begin
    beat_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      beat_sum = beat_sum + ACC_W'(signed'(data_slice[j*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // A well-formed softmax row sums to 1.0, i.e. 2^(DATA_WIDTH-1) in this format.
  assign row_total     = acc_q + beat_sum;
  assign deviation     = (ACC_W+1)'(row_total) - (ACC_W+1)'(2 ** (DATA_WIDTH - 1));
  assign deviation_abs = deviation[ACC_W] ? unsigned'(-deviation) : unsigned'(deviation);

  always_comb begin
    acc_d = acc_q;
    err_d = 1'b0;
    if ((state_q == S_IDLE) && start) begin
      acc_d = '0;
    end
    if (accept) begin
      if (col_at_end) begin
        acc_d = '0;
        err_d = (deviation_abs > (ACC_W+1)'(SUM_TOL));
      end else begin
        acc_d = row_total;
      end
    end
  end

  always_ff @(posedge clk_p) begin
    if (rst_n) begin
      acc_q <= '0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end

  assign row_sum_err = err_q;
`else
  assign row_sum_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_softmax_matrix_reader.sv
`default_nettype none
// ============================================================================
// tb_softmax_matrix_reader: table-driven scoreboard bench for the reader.
// Revision: 1.0
// ============================================================================
module tb_softmax_matrix_reader;

  localparam int DW  = 8;
  localparam int MN  = 2;
  localparam int S1  = 2;
  localparam int S2  = 4;
  localparam int LN  = 2;
  localparam int TOT = DW * MN * S1 * S2;

  logic           clk_p = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic           out_ready = 1'b0;
  logic [TOT-1:0] softmax_matrix = '0;
  logic           busy, done, out_valid, out_row_last, out_last, row_sum_err;
  logic [15:0]    out_data;
  logic [0:0]     out_mat, out_row;
  logic [1:0]     out_col;

  softmax_matrix_reader #(
    .DATA_WIDTH(DW), .MATRIX_NUM(MN), .OUTPUT_SHAPE_1(S1),
    .OUTPUT_SHAPE_2(S2), .LANES(LN), .SUM_TOL(4)
  ) dut (
    .clk_p(clk_p), .rst_n(rst_n), .start(start), .softmax_matrix(softmax_matrix),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mat(out_mat), .out_row(out_row), .out_col(out_col),
    .out_row_last(out_row_last), .out_last(out_last), .row_sum_err(row_sum_err)
  );

  always #5 clk_p = ~clk_p;

  typedef struct {
    logic [15:0] data;
    logic [0:0]  mat;
    logic [0:0]  row;
    logic [1:0]  col;
    logic        row_last;
    logic        last;
  } beat_t;

  beat_t vec_tbl[8];
  beat_t sb_q[$];
  beat_t e;

  int  n_vec = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  bit  pend_done = 1'b0;
  bit  pend_err = 1'b0;
  bit  cur_done, cur_err;
  int  done_seen = 0;
  int  valid_cycles = 0;
  int  accepted = 0;
  int  acc_model = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_table();
    for (int k = 0; k < 8; k++) sb_q.push_back(vec_tbl[k]);
  endtask

  // Reference reordering of an arbitrary matrix into beats (row-major, 2 lanes).
  task automatic push_from_matrix(input logic [TOT-1:0] mtx);
    beat_t b;
    logic [TOT-1:0] m;
    m = mtx;
    for (int k = 0; k < 8; k++) begin
      b.data     = m[k*16 +: 16];
      b.mat      = 1'(k / 4);
      b.row      = 1'((k / 2) % 2);
      b.col      = 2'((k % 2) * 2);
      b.row_last = (k % 2) == 1;
      b.last     = (k == 7);
      sb_q.push_back(b);
    end
  endtask

  task automatic mon_clear();
    sb_q.delete();
    pend_done    = 1'b0;
    pend_err     = 1'b0;
    done_seen    = 0;
    valid_cycles = 0;
    accepted     = 0;
    acc_model    = 0;
  endtask

  always @(negedge clk_p) begin
    if (mon_en) begin
      cur_done  = pend_done;
      pend_done = 1'b0;
      cur_err   = pend_err;
      pend_err  = 1'b0;
      if (done || cur_done) begin
        check("done_pulse", done, cur_done);
        check("valid_low_in_done", out_valid, 1'b0);
        if (done) done_seen++;
      end
      if (row_sum_err || cur_err) check("row_sum_err", row_sum_err, cur_err);
      if (out_valid) begin
        valid_cycles++;
        if (sb_q.size() == 0) begin
          check("unexpected_beat", out_valid, 1'b0);
        end else begin
          e = sb_q[0];
          check("beat", {out_data, out_mat, out_row, out_col, out_row_last, out_last},
                {e.data, e.mat, e.row, e.col, e.row_last, e.last});
          if (out_ready) begin
            void'(sb_q.pop_front());
            accepted++;
            if (e.last) pend_done = 1'b1;
`ifdef SOFTMAX_ROW_SUM_CHECK_EN
            acc_model += int'($signed(e.data[7:0])) + int'($signed(e.data[15:8]));
            if (e.row_last) begin
              if ((acc_model - 128 > 4) || (128 - acc_model > 4)) pend_err = 1'b1;
              acc_model = 0;
            end
`endif
          end
        end
      end
    end
  end

  task automatic start_xfer(input logic rdy0);
    mon_clear();
    @(posedge clk_p); #1;
    check("idle_valid", out_valid, 1'b0);
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk_p); #1;
    start     = 1'b0;
    out_ready = rdy0;
    check("start_latency", out_valid, 1'b1);
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    int k;
    k = 0;
    while (done_seen == 0 && k < budget) begin
      @(posedge clk_p); #1;
      k++;
      if (toggle) out_ready = ~out_ready;
    end
    check("done_seen", 64'(done_seen), 64'd1);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic fill_base();
    for (int i = 0; i < 16; i++) softmax_matrix[i*8 +: 8] = 8'(i);
  endtask

  initial begin
    vec_tbl[0] = '{16'h0100, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vec_tbl[1] = '{16'h0302, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0};
    vec_tbl[2] = '{16'h0504, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    vec_tbl[3] = '{16'h0706, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0};
    vec_tbl[4] = '{16'h0908, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    vec_tbl[5] = '{16'h0B0A, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0};
    vec_tbl[6] = '{16'h0D0C, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
    vec_tbl[7] = '{16'h0F0E, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1};
    fill_base();

    // Reset state
    repeat (2) @(posedge clk_p);
    #1;
    check("reset_outputs", {busy, done, out_valid, out_data, out_mat, out_row, out_col,
                            out_row_last, out_last, row_sum_err}, '0);
    rst_n  = 1'b0;
    mon_en = 1'b1;

    // Basic stream, no backpressure
    start_xfer(1'b1);
    push_table();
    wait_done(40, 1'b0);
    check("basic_valid_cycles", 64'(valid_cycles), 64'd8);
    check("basic_idle_after", {busy, out_valid, done}, 3'b000);

    // Backpressure: ready alternates starting low
    start_xfer(1'b0);
    push_table();
    wait_done(60, 1'b1);
    check("bp_valid_cycles", 64'(valid_cycles), 64'd16);
    out_ready = 1'b1;

    // Snapshot isolation and start ignored mid-stream
    start_xfer(1'b1);
    push_table();
    repeat (2) @(posedge clk_p);
    #1;
    softmax_matrix = '1;
    start = 1'b1;
    @(posedge clk_p); #1;
    start = 1'b0;
    wait_done(40, 1'b0);
    check("snap_valid_cycles", 64'(valid_cycles), 64'd8);
    repeat (3) @(posedge clk_p);
    #1;
    check("snap_no_restart", {busy, out_valid}, 2'b00);
    fill_base();

    // Reset mid-stream after beat 3
    start_xfer(1'b1);
    push_table();
    begin
      int k;
      k = 0;
      while (accepted < 4 && k < 20) begin
        @(posedge clk_p); #1;
        k++;
      end
      check("mid_accepted", 64'(accepted), 64'd4);
    end
    rst_n  = 1'b1;
    mon_en = 1'b0;
    @(posedge clk_p); #1;
    check("midrst_outputs", {busy, done, out_valid, out_data, out_mat, out_row, out_col,
                             out_row_last, out_last, row_sum_err}, '0);
    rst_n = 1'b0;
    @(posedge clk_p); #1;
    check("midrst_no_done", {done, busy, out_valid}, 3'b000);
    mon_en = 1'b1;
    start_xfer(1'b1);
    push_table();
    wait_done(40, 1'b0);
    check("replay_valid_cycles", 64'(valid_cycles), 64'd8);

`ifdef SOFTMAX_ROW_SUM_CHECK_EN
    // Row sums: row (0,0) sums to 128, row (0,1) sums to 136
    for (int i = 0; i < 16; i++) softmax_matrix[i*8 +: 8] = 8'd32;
    softmax_matrix[7*8 +: 8] = 8'd40;
    start_xfer(1'b1);
    push_from_matrix(softmax_matrix);
    wait_done(40, 1'b0);
    fill_base();
`endif

    repeat (2) @(posedge clk_p);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
